// File: rtl/i2c_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_write_arbiter
// Brief    : Round-robin arbiter and retry sequencer sharing one I2C write
//            engine among NUM_REQUESTERS clients. A NACKed write is retried
//            after RETRY_GAP_CYCLES idle clocks, up to MAX_RETRIES times.
//            Optional busy watchdog is built when I2C_ARBITER_WATCHDOG_EN
//            is defined; otherwise timeout is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_write_arbiter #(
    parameter int NUM_REQUESTERS   = 4,
    parameter int MAX_RETRIES      = 3,
    parameter int RETRY_GAP_CYCLES = 1000,
    parameter int WATCHDOG_CYCLES  = 200000
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQUESTERS-1:0]     req,
    input  logic [7*NUM_REQUESTERS-1:0]   address_in,
    input  logic [8*NUM_REQUESTERS-1:0]   value_in,
    output logic [NUM_REQUESTERS-1:0]     grant,
    output logic [NUM_REQUESTERS-1:0]     done,
    output logic [NUM_REQUESTERS-1:0]     fail,
    output logic [3:0]                    retry_count,
    output logic                          timeout,
    output logic [6:0]                    i2c_address,
    output logic [7:0]                    i2c_value,
    output logic                          i2c_start,
    input  logic                          i2c_busy,
    input  logic                          i2c_error
);

    localparam int c_idx_w = $clog2(NUM_REQUESTERS);
    localparam int c_gap_w = $clog2(RETRY_GAP_CYCLES + 1);

    localparam logic [c_idx_w-1:0] c_last_idx     = c_idx_w'(NUM_REQUESTERS - 1);
    localparam logic [c_gap_w-1:0] c_gap_last     = c_gap_w'(RETRY_GAP_CYCLES - 1);
    localparam logic [3:0]         c_max_retries  = 4'(MAX_RETRIES);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_start     = 3'd1;
    localparam logic [2:0] c_st_wait_busy = 3'd2;
    localparam logic [2:0] c_st_wait_done = 3'd3;
    localparam logic [2:0] c_st_check     = 3'd4;
    localparam logic [2:0] c_st_gap       = 3'd5;

    // Out-of-range configurations stop elaboration.
    if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 8 || MAX_RETRIES < 0 || MAX_RETRIES > 15 ||
        RETRY_GAP_CYCLES < 1 || WATCHDOG_CYCLES < 1) begin : g_param_check
        $error("i2c_write_arbiter: parameter out of range");
    end

    logic [2:0]                r_state;
    logic [c_idx_w-1:0]        r_pointer;
    logic [NUM_REQUESTERS-1:0] r_grant;
    logic [NUM_REQUESTERS-1:0] r_done;
    logic [NUM_REQUESTERS-1:0] r_fail;
    logic [3:0]                r_retry_count;
    logic [6:0]                r_address;
    logic [7:0]                r_value;
    logic [c_gap_w-1:0]        r_gap_cnt;

    logic [6:0]                w_addr_arr  [NUM_REQUESTERS];
    logic [7:0]                w_value_arr [NUM_REQUESTERS];
    logic                      w_found;
    logic [c_idx_w-1:0]        w_winner;
    logic [c_idx_w-1:0]        w_next_pointer;
    logic [NUM_REQUESTERS-1:0] w_onehot;
    logic                      w_pulse_active;

    // Split the packed requester buses into per-requester slices.
    for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_unpack
        assign w_addr_arr[g]  = address_in[7*g +: 7];
        assign w_value_arr[g] = value_in[8*g +: 8];
    end

    // Round-robin search: first asserted req at or after the pointer, wrapping.
    always_comb begin : p_rr_search
        int                 v_idx;
        logic [c_idx_w-1:0] v_sel;
        w_found  = 1'b0;
        w_winner = '0;
        v_idx    = 0;
        v_sel    = '0;
        // Walk from farthest to nearest so the nearest hit is the final assignment.
        for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
            v_idx = int'(r_pointer) + k;
            if (v_idx >= NUM_REQUESTERS) begin
                v_idx = v_idx - NUM_REQUESTERS;
            end
            v_sel = c_idx_w'(v_idx);
            if (req[v_sel]) begin
                w_found  = 1'b1;
                w_winner = v_sel;
            end
        end
    end

    assign w_next_pointer = (w_winner == c_last_idx) ? '0 : w_winner + 1'b1;
    assign w_onehot       = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << w_winner;
    // The done/fail cycle is spent in IDLE; no arbitration happens in it, so a
    // requester that still holds req there is not re-granted on stale intent.
    assign w_pulse_active = |(r_done | r_fail);

`ifdef I2C_ARBITER_WATCHDOG_EN
    localparam int c_wd_w = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(WATCHDOG_CYCLES - 1);
    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_timeout;
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    // Arbitration, engine hand-shake, retry sequencing and result pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_st_idle;
            r_pointer     <= '0;
            r_grant       <= '0;
            r_done        <= '0;
            r_fail        <= '0;
            r_retry_count <= '0;
            r_address     <= '0;
            r_value       <= '0;
            r_gap_cnt     <= '0;
`ifdef I2C_ARBITER_WATCHDOG_EN
            r_wd_cnt      <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_grant <= '0;
                    r_done  <= '0;
                    r_fail  <= '0;
                    // The engine has no reset, so a transfer still running
                    // from before a reset must drain before a new grant.
                    if (!w_pulse_active && w_found && !i2c_busy) begin
                        r_state       <= c_st_start;
                        r_grant       <= w_onehot;
                        r_address     <= w_addr_arr[w_winner];
                        r_value       <= w_value_arr[w_winner];
                        r_pointer     <= w_next_pointer;
                        r_retry_count <= '0;
`ifdef I2C_ARBITER_WATCHDOG_EN
                        r_timeout     <= 1'b0;
`endif
                    end
                end
                c_st_start: begin
`ifdef I2C_ARBITER_WATCHDOG_EN
                    r_wd_cnt <= '0;
`endif
                    r_state <= c_st_wait_busy;
                end
                c_st_wait_busy: begin
`ifdef I2C_ARBITER_WATCHDOG_EN
                    if (r_wd_cnt == c_wd_last) begin
                        r_fail    <= r_grant;
                        r_timeout <= 1'b1;
                        r_state   <= c_st_idle;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                        if (i2c_busy) r_state <= c_st_wait_done;
                    end
`else
                    if (i2c_busy) r_state <= c_st_wait_done;
`endif
                end
                c_st_wait_done: begin
`ifdef I2C_ARBITER_WATCHDOG_EN
                    if (r_wd_cnt == c_wd_last) begin
                        r_fail    <= r_grant;
                        r_timeout <= 1'b1;
                        r_state   <= c_st_idle;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                        if (!i2c_busy) r_state <= c_st_check;
                    end
`else
                    if (!i2c_busy) r_state <= c_st_check;
`endif
                end
                c_st_check: begin
                    if (!i2c_error) begin
                        r_done  <= r_grant;
                        r_state <= c_st_idle;
                    end else if (r_retry_count < c_max_retries) begin
                        r_retry_count <= r_retry_count + 4'd1;
                        r_gap_cnt     <= '0;
                        r_state       <= c_st_gap;
                    end else begin
                        r_fail  <= r_grant;
                        r_state <= c_st_idle;
                    end
                end
                c_st_gap: begin
                    // Latched address/value are reused for the retry.
                    if (r_gap_cnt == c_gap_last) begin
                        r_state <= c_st_start;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign fail        = r_fail;
    assign retry_count = r_retry_count;
    assign i2c_address = r_address;
    assign i2c_value   = r_value;
    assign i2c_start   = (r_state == c_st_start);

endmodule
`default_nettype wire

// File: tb/tb_i2c_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_write_arbiter
// Brief    : Self-checking bench for i2c_write_arbiter with a behavioural
//            engine model, per-requester expectation queues and a monitor.
//            Watchdog scenario is compiled when I2C_ARBITER_WATCHDOG_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_write_arbiter;

    localparam int N     = 4;
    localparam int MAXR  = 3;
    localparam int GAP   = 10;
    localparam int WD    = 100;
    localparam int LIMIT = 5000;

    typedef struct {
        logic [6:0] a;
        logic [7:0] v;
        int         nacks;
        bit         wd;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic [N-1:0]     req;
    logic [7*N-1:0]   address_in;
    logic [8*N-1:0]   value_in;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [N-1:0]     fail;
    logic [3:0]       retry_count;
    logic             timeout;
    logic [6:0]       i2c_address;
    logic [7:0]       i2c_value;
    logic             i2c_start;
    logic             i2c_busy;
    logic             i2c_error;

    i2c_write_arbiter #(
        .NUM_REQUESTERS   (N),
        .MAX_RETRIES      (MAXR),
        .RETRY_GAP_CYCLES (GAP),
        .WATCHDOG_CYCLES  (WD)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .address_in  (address_in),
        .value_in    (value_in),
        .grant       (grant),
        .done        (done),
        .fail        (fail),
        .retry_count (retry_count),
        .timeout     (timeout),
        .i2c_address (i2c_address),
        .i2c_value   (i2c_value),
        .i2c_start   (i2c_start),
        .i2c_busy    (i2c_busy),
        .i2c_error   (i2c_error)
    );

    always #5 clock = ~clock;

    // Scoreboard and reference-model state.
    exp_t         exp_q [N][$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [N-1:0] last_req = '0;
    logic         last_busy = 1'b0;
    int           ptr = 0;
    int           owner = -1;
    int           attempts = 0;
    int           start_cyc = 0;
    int           fall_cyc = 0;
    bit           in_txn = 1'b0;
    bit           rel_pending = 1'b0;
    int           eng_cnt = 0;
    int           force_len = 0;

    // Values the DUT saw at each rising edge, for arbitration prediction.
    always @(posedge clock) begin
        cyc       <= cyc + 1;
        last_req  <= req;
        last_busy <= i2c_busy;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_step();
        int   w;
        exp_t e;
        int   exp_rc;
        bit   exp_done;
        check("one_owner", {31'd0, $onehot0(grant | done | fail) && $onehot0(done | fail)}, 1);
        if (rel_pending) begin
            check("grant_release", grant, 0);
            rel_pending = 1'b0;
        end
        if (i2c_start) begin
            if (!in_txn) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && last_req[(ptr + k) % N]) w = (ptr + k) % N;
                end
                check("arb_engine_idle", last_busy, 0);
                if (w < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_start: start with grant=%b, required no start (no pending req)", grant);
                end else begin
                    check("grant_on_start", grant, 64'(1) << w);
                    owner     = w;
                    ptr       = (w + 1) % N;
                    in_txn    = 1'b1;
                    attempts  = 1;
                    start_cyc = cyc;
                end
            end else begin
                attempts++;
                check("retry_spacing", cyc - fall_cyc, GAP + 2);
            end
            if (owner >= 0 && exp_q[owner].size() > 0) begin
                check("i2c_address", i2c_address, exp_q[owner][0].a);
                check("i2c_value", i2c_value, exp_q[owner][0].v);
            end
        end
        if ((done | fail) != '0) begin
            if (!in_txn || owner < 0 || exp_q[owner].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: done=%b fail=%b, required none (no transaction open)", done, fail);
            end else begin
                e        = exp_q[owner].pop_front();
                exp_done = !e.wd && (e.nacks <= MAXR);
                exp_rc   = e.wd ? 0 : ((e.nacks <= MAXR) ? e.nacks : MAXR);
                check("done", done, exp_done ? (64'(1) << owner) : 64'(0));
                check("fail", fail, exp_done ? 64'(0) : (64'(1) << owner));
                check("retry_count", retry_count, exp_rc);
                check("start_count", attempts, exp_rc + 1);
                check("grant_at_pulse", grant, 64'(1) << owner);
                check("timeout", timeout, e.wd);
                if (e.wd) check("watchdog_latency", cyc - start_cyc, WD + 1);
                else      check("pulse_latency", cyc - fall_cyc, 2);
                in_txn      = 1'b0;
                rel_pending = 1'b1;
            end
        end
    endtask

    // Engine model: busy for a few clocks per start, NACKs the planned number of attempts.
    task automatic engine_step();
        bit nack;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                nack = in_txn && owner >= 0 && exp_q[owner].size() > 0 &&
                       (attempts - 1) < exp_q[owner][0].nacks;
                i2c_busy  = 1'b0;
                i2c_error = nack;
                fall_cyc  = cyc;
            end
        end
        if (i2c_start) begin
            i2c_busy  = 1'b1;
            i2c_error = 1'b0;
            eng_cnt   = (force_len > 0) ? force_len : int'($urandom_range(2, 8));
        end
    endtask

    task automatic do_req(input int id, input logic [6:0] a, input logic [7:0] v,
                          input int nk, input bit wd);
        exp_t e;
        int   t;
        e.a = a; e.v = v; e.nacks = nk; e.wd = wd;
        @(negedge clock);
        address_in[7*id +: 7] = a;
        value_in[8*id +: 8]   = v;
        exp_q[id].push_back(e);
        req[id] = 1'b1;
        t = 0;
        while (!(done[id] || fail[id])) begin
            if (t >= LIMIT) begin
                checks++;
                errors++;
                $display("FAIL req%0d_wait: no done/fail within %0d cycles, required a pulse", id, LIMIT);
                break;
            end
            // Data is latched at grant; changing it afterwards must not matter.
            if (grant[id]) begin
                address_in[7*id +: 7] = 7'($urandom);
                value_in[8*id +: 8]   = 8'($urandom);
            end
            @(negedge clock);
            t++;
        end
        req[id] = 1'b0;
    endtask

    task automatic rand_requester(input int id);
        int n;
        for (int t = 0; t < 8; t++) begin
            repeat ($urandom_range(0, 15)) @(negedge clock);
            n = int'($urandom_range(0, 9));
            do_req(id, 7'($urandom), 8'($urandom), (n < 6) ? 0 : n - 5, 1'b0);
        end
    endtask

    initial begin : main
        exp_t e;
        int   t;
        req        = '0;
        address_in = '0;
        value_in   = '0;
        i2c_busy   = 1'b0;
        i2c_error  = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("reset_outputs", {grant, done, fail, retry_count, timeout, i2c_address, i2c_value, i2c_start}, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        fork
            forever begin
                @(negedge clock);
                monitor_step();
                engine_step();
            end
        join_none

        // All four request together, each twice: order 0,1,2,3 then again.
        fork
            begin do_req(0, 7'h10, 8'h01, 0, 1'b0); do_req(0, 7'h14, 8'h05, 0, 1'b0); end
            begin do_req(1, 7'h11, 8'h02, 0, 1'b0); do_req(1, 7'h15, 8'h06, 0, 1'b0); end
            begin do_req(2, 7'h12, 8'h03, 0, 1'b0); do_req(2, 7'h16, 8'h07, 0, 1'b0); end
            begin do_req(3, 7'h13, 8'h04, 0, 1'b0); do_req(3, 7'h17, 8'h08, 0, 1'b0); end
        join
        repeat (5) @(negedge clock);

        do_req(2, 7'h41, 8'hA5, 0, 1'b0);   // single ACKed write
        do_req(1, 7'h22, 8'h3C, 2, 1'b0);   // two NACKs then ACK
        do_req(0, 7'h7F, 8'hFF, 6, 1'b0);   // NACKed beyond retry budget
        do_req(3, 7'h00, 8'h00, 3, 1'b0);   // ACK on the last allowed retry

        fork
            rand_requester(0);
            rand_requester(1);
            rand_requester(2);
            rand_requester(3);
        join
        repeat (20) @(negedge clock);

        // Reset while the engine is mid-transfer and stays busy afterwards.
        force_len = 60;
        e.a = 7'h5A; e.v = 8'hC3; e.nacks = 0; e.wd = 1'b0;
        @(negedge clock);
        address_in[7*3 +: 7] = e.a;
        value_in[8*3 +: 8]   = e.v;
        exp_q[3].push_back(e);
        req[3] = 1'b1;
        t = 0;
        while (!i2c_start && t < LIMIT) begin @(negedge clock); t++; end
        check("reset_test_started", i2c_start, 1);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", {grant, done, fail, retry_count, timeout, i2c_address, i2c_value, i2c_start}, 0);
        exp_q[3].delete();
        exp_q[3].push_back(e);
        in_txn      = 1'b0;
        owner       = -1;
        ptr         = 0;
        rel_pending = 1'b0;
        force_len   = 0;
        @(negedge clock);
        reset_n = 1'b1;
        t = 0;
        while (i2c_busy && t < LIMIT) begin
            check("no_grant_while_busy", grant, 0);
            @(negedge clock);
            t++;
        end
        t = 0;
        while (!(done[3] || fail[3]) && t < LIMIT) begin @(negedge clock); t++; end
        check("post_reset_done", done[3], 1);
        req[3] = 1'b0;
        repeat (5) @(negedge clock);

`ifdef I2C_ARBITER_WATCHDOG_EN
        force_len = 300;
        do_req(1, 7'h33, 8'h44, 0, 1'b1);
        force_len = 0;
        do_req(2, 7'h35, 8'h46, 0, 1'b0);
`endif

        repeat (30) @(negedge clock);
        for (int k = 0; k < N; k++) check("scoreboard_drained", exp_q[k].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
